// File: rtl/exu_pkg.sv
// rtl/exu_pkg.sv - opcodes, state encoding and helpers for the iterative execute stage
package exu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Sign-extend a 32-bit word to the widest supported datapath; callers keep the low XLEN bits.
  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

endpackage

// File: rtl/exu_alu.sv
// rtl/exu_alu.sv - combinational single-cycle ALU including RV64 word-mode ops
module exu_alu
  import exu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [3:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic [XLEN-1:0] res
);

  localparam int SHW = $clog2(XLEN);

  logic            word_en;
  logic [SHW-1:0]  sh;
  logic [4:0]      shw;
  logic [31:0]     w;
  logic [63:0]     wx;

  // Full-width result, overridden by the sign-extended 32-bit result for word-capable ops.
  always_comb begin
    word_en = word && (XLEN == 64);
    sh      = src2[SHW-1:0];
    shw     = src2[4:0];
    w       = '0;
    case (op)
      OP_ADD:  w = src1[31:0] + src2[31:0];
      OP_SUB:  w = src1[31:0] - src2[31:0];
      OP_SLL:  w = src1[31:0] << shw;
      OP_SRL:  w = src1[31:0] >> shw;
      OP_SRA:  w = $signed(src1[31:0]) >>> shw;
      default: w = '0;
    endcase
    wx = sext32(w);

    res = '0;
    case (op)
      OP_ADD:  res = src1 + src2;
      OP_SUB:  res = src1 - src2;
      OP_SLL:  res = src1 << sh;
      OP_SLT:  res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
      OP_SLTU: res = {{(XLEN-1){1'b0}}, src1 < src2};
      OP_XOR:  res = src1 ^ src2;
      OP_SRL:  res = src1 >> sh;
      OP_SRA:  res = $signed(src1) >>> sh;
      OP_OR:   res = src1 | src2;
      OP_AND:  res = src1 & src2;
      default: res = '0;
    endcase
    if (word_en && (op == OP_ADD || op == OP_SUB || op == OP_SLL ||
                    op == OP_SRL || op == OP_SRA))
      res = wx[XLEN-1:0];
  end

endmodule

// File: rtl/exu_iter.sv
// rtl/exu_iter.sv - execute stage with valid/ready handshake and iterative shift-add multiplier
module exu_iter
  import exu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5,
  parameter int MUL_EN  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic               in_word,
  input  logic [XLEN-1:0]    in_src1,
  input  logic [XLEN-1:0]    in_src2,
  input  logic [RADDR_W-1:0] in_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_res,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_wen,
  output logic               busy
);

  localparam int CW = $clog2(XLEN) + 1;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [XLEN-1:0]     acc, mcand, mplier;
  logic                word_q;
  logic [RADDR_W-1:0]  rd_q;
  logic [XLEN-1:0]     alu_res;
  logic [XLEN-1:0]     acc_sum, mul_res;
  logic [63:0]         mul_wx;
  logic                word_en, accept, mul_start, mul_done;

  exu_alu #(.XLEN(XLEN)) u_alu (
    .op   (in_op),
    .word (in_word),
    .src1 (in_src1),
    .src2 (in_src2),
    .res  (alu_res)
  );

  // Handshake qualifiers and the multiplier's final-step result.
  always_comb begin
    word_en   = in_word && (XLEN == 64);
    accept    = in_valid && in_ready;
    mul_start = accept && (MUL_EN != 0) && (in_op == OP_MUL);
    mul_done  = (state == ST_MUL) && (cnt == CW'(1));
    acc_sum   = acc + (mplier[0] ? mcand : '0);
    mul_wx    = sext32(acc_sum[31:0]);
    mul_res   = word_q ? mul_wx[XLEN-1:0] : acc_sum;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: enter MUL on a multiply accept, leave after the last iteration.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mul_start) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: accept only when idle and the output slot is free or draining.
  always_comb begin
    in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    busy     = (state == ST_MUL);
  end

  assign out_wen = out_valid && (out_rd != '0);

  // Multiplier datapath: one shift-add step per cycle in MUL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      word_q <= 1'b0;
      rd_q   <= '0;
    end else if (mul_start) begin
      cnt    <= word_en ? CW'(32) : CW'(XLEN);
      acc    <= '0;
      mcand  <= in_src1;
      mplier <= in_src2;
      word_q <= word_en;
      rd_q   <= in_rd;
    end else if (state == ST_MUL) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

  // Output register: load on single-cycle accept or multiply completion, drop valid when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_rd    <= '0;
    end else if (accept && !mul_start) begin
      out_valid <= 1'b1;
      out_res   <= alu_res;
      out_rd    <= in_rd;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      out_res   <= mul_res;
      out_rd    <= rd_q;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exu_iter.sv
// tb/tb_exu_iter.sv - scoreboard bench for the iterative execute stage
module tb_exu_iter;
  import exu_pkg::*;

  localparam int XLEN = 64;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      in_op = '0;
  logic            in_word = 1'b0;
  logic [XLEN-1:0] in_src1 = '0;
  logic [XLEN-1:0] in_src2 = '0;
  logic [RW-1:0]   in_rd = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] out_res;
  logic [RW-1:0]   out_rd;
  logic            out_wen;
  logic            busy;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [RW-1:0]   rd;
    logic            wen;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  exu_iter #(.XLEN(XLEN), .RADDR_W(RW), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_rd(out_rd), .out_wen(out_wen), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
  endtask

  // Monitor: every transfer on the output port is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_res", out_res, e.res);
        check("out_rd", 64'(out_rd), 64'(e.rd));
        check("out_wen", 64'(out_wen), 64'(e.wen));
      end
    end
  end

  // Present one op, wait for the handshake, optionally register the expected result.
  task automatic send(input logic [3:0] op, input logic word, input logic [63:0] s1,
                      input logic [63:0] s2, input logic [4:0] rd,
                      input logic [63:0] exp_res, input bit push);
    bit ok;
    exp_t e;
    in_op = op; in_word = word; in_src1 = s1; in_src2 = s2; in_rd = rd;
    in_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        if (push) begin
          e.res = exp_res; e.rd = rd; e.wen = (rd != 0);
          exp_q.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
  endtask

  initial begin
    int edges, busy_cycles;
    bit saw_valid;
    exp_t e;

    // Reset state.
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_res", out_res, 64'd0);
    check("rst_out_wen", 64'(out_wen), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Single-cycle ops with hand-computed results.
    send(OP_ADD,  0, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 5, 64'hF, 1);
    send(OP_ADD,  1, 64'h7FFF_FFFF, 64'h1, 6, 64'hFFFF_FFFF_8000_0000, 1);
    send(OP_SRA,  0, 64'h8000_0000_0000_0000, 64'h41, 7, 64'hC000_0000_0000_0000, 1);
    send(OP_SUB,  0, 64'h5, 64'h7, 8, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    send(OP_SLT,  0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 9, 64'h1, 1);
    send(OP_SLTU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 10, 64'h0, 1);
    send(OP_XOR,  1, 64'hF0F0_0000_0000_00FF, 64'h0FF0_0000_0000_0F0F, 11, 64'hFF00_0000_0000_0FF0, 1);
    send(OP_SLL,  1, 64'h1, 64'h1F, 12, 64'hFFFF_FFFF_8000_0000, 1);
    send(OP_SRL,  1, 64'hFFFF_FFFF_8000_0000, 64'h4, 13, 64'h0000_0000_0800_0000, 1);
    send(OP_SRL,  0, 64'h8000_0000_0000_0000, 64'h3F, 14, 64'h1, 1);
    send(OP_OR,   0, 64'hA0, 64'h0B, 15, 64'hAB, 1);
    send(OP_AND,  0, 64'hFF00, 64'h0FF0, 16, 64'h0F00, 1);
    send(4'd15,   0, 64'h1234, 64'h5678, 17, 64'h0, 1);
    send(OP_ADD,  0, 64'h1, 64'h1, 0, 64'h2, 1);
    drain();

    // Multiply: 64 busy cycles, result 64 edges after the accept edge.
    e.res = 64'hFFFF_FFFF_FFFF_FFEB; e.rd = 3; e.wen = 1;
    in_op = OP_MUL; in_word = 0; in_src1 = 64'd7; in_src2 = 64'hFFFF_FFFF_FFFF_FFFD; in_rd = 3;
    in_valid = 1'b1;
    @(negedge clk);
    check("mul_in_ready_idle", 64'(in_ready), 64'd1);
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0; busy_cycles = 0;
    if (busy && !in_ready) busy_cycles++;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); edges++; #1;
      if (out_valid) break;
      if (busy && !in_ready) busy_cycles++;
    end
    check("mul_latency_edges", 64'(edges), 64'd64);
    check("mul_busy_cycles", 64'(busy_cycles), 64'd64);
    check("mul_busy_after", 64'(busy), 64'd0);
    drain();

    // Word-mode multiply: low 32 bits sign-extended, 32 edges.
    e.res = 64'hFFFF_FFFF_8000_0000; e.rd = 4; e.wen = 1;
    in_op = OP_MUL; in_word = 1; in_src1 = 64'h1_0001_0000; in_src2 = 64'h8000; in_rd = 4;
    in_valid = 1'b1;
    @(negedge clk);
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); edges++; #1;
      if (out_valid) break;
    end
    check("mulw_latency_edges", 64'(edges), 64'd32);
    drain();

    // Backpressure: held result with rd=0, second op stalls until out_ready rises.
    out_ready = 1'b0;
    send(OP_ADD, 0, 64'h1, 64'h2, 0, 64'h3, 1);
    in_op = OP_ADD; in_word = 0; in_src1 = 64'h4; in_src2 = 64'h4; in_rd = 9; in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_res", out_res, 64'h3);
      check("bp_out_wen", 64'(out_wen), 64'd0);
    end
    e.res = 64'h8; e.rd = 9; e.wen = 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_valid", 64'(out_valid), 64'd1);
    check("bp_second_res", out_res, 64'h8);
    drain();
    @(posedge clk); #1;
    check("drain_valid_low", 64'(out_valid), 64'd0);
    check("drain_res_kept", out_res, 64'h8);

    // Asynchronous reset mid-multiply abandons the op.
    send(OP_MUL, 0, 64'd5, 64'd6, 2, 64'd30, 0);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_res", out_res, 64'd0);
    check("arst_out_rd", 64'(out_rd), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    saw_valid = 0;
    for (int n = 0; n < 80; n++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1;
    end
    check("arst_no_result", 64'(saw_valid), 64'd0);
    send(OP_ADD, 0, 64'h20, 64'h22, 1, 64'h42, 1);
    drain();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
